// File: rtl/spike_train_encoder.sv
// Float drive to spike-train encoder.
// Q16.16 accumulator, spaced spike pulses, per-window spike count.
module spike_train_encoder #(
  parameter int unsigned SPACING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [31:0] drive,
  input  logic        clr_flag,
  output logic        spike_out,
  output logic [31:0] spike_cnt_out,
  output logic        busy,
  output logic        sat_flag
);

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    GAP
  } state_t;

  localparam logic [7:0] GAP_LD = 8'(SPACING - 1);
  localparam logic [32:0] ONE = 33'h0_0001_0000;

  state_t      state, state_n;
  logic [7:0]  gap, gap_n;
  logic [31:0] acc;
  logic [31:0] fx1;
  logic        v1;
  logic [31:0] win;

  logic [7:0]  ex;
  logic [22:0] man;
  logic [31:0] mant;
  logic [31:0] fx_c;
  logic        sat_c;

  logic        spike_evt;
  logic [32:0] sum;
  logic        acc_sat;
  logic [31:0] win_inc;

  assign ex   = drive[30:23];
  assign man  = drive[22:0];
  assign mant = {8'd0, 1'b1, man};

  // fx = mant24 * 2^(ex-134); ex 111..142 is the representable band
  always_comb begin
    fx_c  = '0;
    sat_c = 1'b0;
    if (drive[31]) begin
      fx_c = '0;
    end else if (ex == 8'hFF && man != '0) begin
      fx_c = '0;
    end else if (ex >= 8'd143) begin
      fx_c  = '1;
      sat_c = 1'b1;
    end else if (ex >= 8'd134) begin
      fx_c = mant << (ex - 8'd134);
    end else if (ex >= 8'd111) begin
      fx_c = mant >> (8'd134 - ex);
    end
  end

  assign spike_evt = (state == FIRE);

  always_comb begin
    sum = {1'b0, acc}
        + {1'b0, (v1 ? fx1 : 32'd0)}
        - (spike_evt ? ONE : 33'd0);
    acc_sat = sum[32];
  end

  assign win_inc = (win == '1) ? win : win + 32'd1;

  always_comb begin
    state_n = state;
    gap_n   = gap;
    unique case (state)
      IDLE: begin
        if (acc[31:16] != '0) state_n = FIRE;
      end
      FIRE: begin
        if (SPACING == 1) begin
          state_n = IDLE;
        end else begin
          gap_n   = GAP_LD;
          state_n = GAP;
        end
      end
      GAP: begin
        gap_n = gap - 8'd1;
        if (gap <= 8'd1) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      gap           <= '0;
      acc           <= '0;
      fx1           <= '0;
      v1            <= 1'b0;
      win           <= '0;
      spike_out     <= 1'b0;
      spike_cnt_out <= '0;
      sat_flag      <= 1'b0;
    end else begin
      state     <= state_n;
      gap       <= gap_n;
      spike_out <= (state_n == FIRE);
      v1        <= tick;
      if (tick) fx1 <= fx_c;
      acc <= acc_sat ? 32'hFFFF_FFFF : sum[31:0];
      // a spike on a tick edge opens the new window
      if (tick) begin
        spike_cnt_out <= win;
        win           <= spike_evt ? 32'd1 : 32'd0;
      end else if (spike_evt) begin
        win <= win_inc;
      end
      if ((tick && sat_c) || acc_sat) sat_flag <= 1'b1;
      else if (clr_flag)              sat_flag <= 1'b0;
    end
  end

  assign busy = (state != IDLE) || (acc[31:16] != '0);

endmodule

// File: tb/tb_spike_train_encoder.sv
// Directed self-checking bench for spike_train_encoder.
// Linear stimulus; checks sampled 1ns after each rising edge.
module tb_spike_train_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic [31:0] drive;
  logic        clr_flag;
  logic        spike_out;
  logic [31:0] spike_cnt_out;
  logic        busy;
  logic        sat_flag;

  int checks = 0;
  int errors = 0;
  int sp_cnt, sp_first, sp_last, cyc;

  spike_train_encoder #(.SPACING(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .drive        (drive),
    .clr_flag     (clr_flag),
    .spike_out    (spike_out),
    .spike_cnt_out(spike_cnt_out),
    .busy         (busy),
    .sat_flag     (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_rec();
    sp_cnt   = 0;
    sp_first = -1;
    sp_last  = -1;
    cyc      = 0;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
    cyc++;
    if (spike_out === 1'b1) begin
      sp_cnt++;
      if (sp_first < 0) sp_first = cyc;
      sp_last = cyc;
    end
  endtask

  task automatic do_tick(input logic [31:0] d);
    tick  = 1'b1;
    drive = d;
    edge_step();
    tick  = 1'b0;
    drive = 32'd0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) edge_step();
  endtask

  initial begin
    reset    = 1'b1;
    tick     = 1'b0;
    drive    = 32'd0;
    clr_flag = 1'b0;
    clr_rec();
    steps(2);
    reset = 1'b0;
    chk("rst_spike", 32'(spike_out), 32'd0);
    chk("rst_cnt", spike_cnt_out, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sat", 32'(sat_flag), 32'd0);
    chk("rst_acc", dut.acc, 32'd0);

    // 2.0: spikes at E2 and E7 (cyc 3 and 8)
    clr_rec();
    do_tick(32'h4000_0000);
    edge_step();
    chk("two_acc_e1", dut.acc, 32'h0002_0000);
    chk("two_busy", 32'(busy), 32'd1);
    steps(14);
    chk("two_count", sp_cnt, 32'd2);
    chk("two_first", sp_first, 32'd3);
    chk("two_last", sp_last, 32'd8);
    chk("two_acc_end", dut.acc, 32'd0);
    chk("two_busy_end", 32'(busy), 32'd0);

    // 0.5 twice
    clr_rec();
    do_tick(32'h3F00_0000);
    chk("win_after_two", spike_cnt_out, 32'd2);
    steps(10);
    chk("half_nospike", sp_cnt, 32'd0);
    chk("half_acc", dut.acc, 32'h0000_8000);
    clr_rec();
    do_tick(32'h3F00_0000);
    chk("win_empty", spike_cnt_out, 32'd0);
    steps(10);
    chk("half2_count", sp_cnt, 32'd1);
    chk("half2_first", sp_first, 32'd3);
    chk("half2_acc", dut.acc, 32'd0);

    // negative, NaN, denormal
    clr_rec();
    do_tick(32'hBF80_0000);
    chk("win_one", spike_cnt_out, 32'd1);
    steps(3);
    do_tick(32'h7FC0_0000);
    steps(3);
    do_tick(32'h0000_0001);
    steps(6);
    chk("junk_nospike", sp_cnt, 32'd0);
    chk("junk_acc", dut.acc, 32'd0);
    chk("junk_sat", 32'(sat_flag), 32'd0);

    // conversion boundaries
    do_tick(32'h3F7F_FFFF);
    edge_step();
    chk("trunc_below_one", dut.acc, 32'h0000_FFFF);
    do_tick(32'h3780_0000);
    edge_step();
    chk("min_lsb", dut.acc, 32'h0001_0000);
    steps(12);
    chk("lsb_drain", dut.acc, 32'd0);
    do_tick(32'h377F_FFFF);
    edge_step();
    chk("below_lsb", dut.acc, 32'd0);
    steps(4);

    // window count, 3.0 every 30 cycles
    clr_rec();
    do_tick(32'h4040_0000);
    steps(29);
    do_tick(32'h4040_0000);
    chk("win3_a", spike_cnt_out, 32'd3);
    chk("win3_spk", sp_cnt, 32'd3);
    steps(29);
    do_tick(32'h4040_0000);
    chk("win3_b", spike_cnt_out, 32'd3);
    steps(20);

    // tick coincident with the spike edge
    do_tick(32'd0);
    clr_rec();
    do_tick(32'h3F80_0000);
    steps(2);
    chk("coin_fire", 32'(spike_out), 32'd1);
    do_tick(32'd0);
    chk("coin_old_win", spike_cnt_out, 32'd0);
    steps(10);
    do_tick(32'd0);
    chk("coin_new_win", spike_cnt_out, 32'd1);
    steps(4);

    // back-to-back 1.0 ticks
    clr_rec();
    tick  = 1'b1;
    drive = 32'h3F80_0000;
    steps(3);
    tick  = 1'b0;
    drive = 32'd0;
    chk("b2b_acc_e2", dut.acc, 32'h0002_0000);
    edge_step();
    chk("b2b_acc_e3", dut.acc, 32'h0002_0000);
    steps(20);
    chk("b2b_count", sp_cnt, 32'd3);
    chk("b2b_acc_end", dut.acc, 32'd0);

    // +Inf saturation, clear, reset mid-burst
    clr_rec();
    do_tick(32'h7F80_0000);
    edge_step();
    chk("inf_acc", dut.acc, 32'hFFFF_FFFF);
    chk("inf_sat", 32'(sat_flag), 32'd1);
    do_tick(32'h3F80_0000);
    edge_step();
    chk("inf_keep", dut.acc, 32'hFFFF_FFFF);
    clr_flag = 1'b1;
    edge_step();
    clr_flag = 1'b0;
    chk("sat_clr", 32'(sat_flag), 32'd0);
    steps(2);
    reset = 1'b1;
    edge_step();
    reset = 1'b0;
    chk("mid_rst_spike", 32'(spike_out), 32'd0);
    chk("mid_rst_acc", dut.acc, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    clr_rec();
    steps(10);
    chk("mid_rst_quiet", sp_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
